// File: rtl/uart_rx_path.sv
// UART receive path: baud tick generator, 16x-oversampling deserializer with optional parity, FWFT RX FIFO.
// Optional macro UART_RX_LEVEL_EN adds a `level` output with the FIFO occupancy.
module uart_rx_path #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_TYPE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           divisor,
  input  logic                  rx,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  rx_busy,
  output logic                  rx_error,
  output logic                  rx_overrun,
  output logic                  baud_en,
  output logic                  baud_en_16x
`ifdef UART_RX_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BCW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0]      BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic PAR_ON  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_TYPE != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Baud generator
  logic [31:0] div_cnt;
  logic [31:0] div_last;
  logic [3:0]  sub_cnt;
  logic        tick16;

  // >= rather than == so a divisor lowered mid-count still wraps on the next cycle
  assign div_last = (divisor <= 32'd1) ? '0 : divisor - 32'd1;
  assign tick16   = !rst_n && (div_cnt >= div_last);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      div_cnt <= '0;
      sub_cnt <= '0;
    end else if (tick16) begin
      div_cnt <= '0;
      sub_cnt <= sub_cnt + 4'd1;
    end else begin
      div_cnt <= div_cnt + 32'd1;
    end
  end

  assign baud_en_16x = tick16;
  assign baud_en     = tick16 && (sub_cnt == 4'hF);

  // rx synchronizer
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM
  state_t                state, state_n;
  logic [3:0]            tick_cnt, tick_cnt_n;
  logic [BCW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  par_bit, par_bit_n;
  logic                  sample;
  logic                  frame_done;
  logic                  frame_bad;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par_bit  <= par_bit_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    sample     = tick16 && (tick_cnt == ((state == S_START) ? 4'd7 : 4'd15));

    if (state != S_IDLE && tick16)
      tick_cnt_n = sample ? '0 : tick_cnt + 4'd1;

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n    = S_START;
          tick_cnt_n = '0;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_n = {rx_s, shreg[DATA_WIDTH-1:1]};
          if (bit_cnt == BIT_LAST)
            state_n = PAR_ON ? S_PARITY : S_STOP;
          else
            bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_bit_n = rx_s;
          state_n   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          state_n    = S_IDLE;
          frame_done = 1'b1;
          frame_bad  = !rx_s || (PAR_ON && ((^shreg ^ par_bit) != PAR_ODD));
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign rx_busy = (state != S_IDLE);

  // FIFO
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full_i, empty_i, good, do_wr, do_rd;

  assign full_i  = (count == CNT_FULL);
  assign empty_i = (count == '0);
  assign good    = frame_done && !frame_bad;
  assign do_rd   = rd_en && !empty_i;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign do_wr   = good && (!full_i || do_rd);

  assign rx_error   = frame_done && frame_bad;
  assign rx_overrun = good && full_i && !do_rd;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= shreg;
  end

  assign dout  = empty_i ? '0 : mem[rd_ptr];
  assign full  = full_i;
  assign empty = empty_i;

`ifdef UART_RX_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_uart_rx_path.sv
// Directed self-checking bench for uart_rx_path (8 data bits, even parity, 16-deep FIFO).
module tb_uart_rx_path;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] divisor = 32'd16;
  logic        rx = 1'b1;
  logic        rd_en = 1'b0;
  logic [7:0]  dout;
  logic        full, empty, rx_busy, rx_error, rx_overrun, baud_en, baud_en_16x;
`ifdef UART_RX_LEVEL_EN
  logic [4:0]  level;
`endif

  uart_rx_path #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .PARITY_EN(1),
    .PARITY_TYPE(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .divisor(divisor),
    .rx(rx),
    .rd_en(rd_en),
    .dout(dout),
    .full(full),
    .empty(empty),
    .rx_busy(rx_busy),
    .rx_error(rx_error),
    .rx_overrun(rx_overrun),
    .baud_en(baud_en),
    .baud_en_16x(baud_en_16x)
`ifdef UART_RX_LEVEL_EN
    ,
    .level(level)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;

  always @(negedge clk) begin
    if (rx_error)   err_cnt++;
    if (rx_overrun) ovr_cnt++;
  end

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic send_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    int bc;
    bc = int'(divisor) * 16;
    send_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) send_bit(d[i], bc);
    send_bit(p, bc);
    send_bit(stop, bc);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    divisor = 32'd16;
    repeat (4) @(negedge clk);
    tests++; if (dout !== 8'h00)     begin fails++; $display("FAIL reset_dout: got %h expected 00", dout); end
    tests++; if (empty !== 1'b1)     begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
    tests++; if (full !== 1'b0)      begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
    tests++; if (rx_busy !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    tests++; if (rx_error !== 1'b0 || rx_overrun !== 1'b0) begin
      fails++; $display("FAIL reset_pulses: got err=%b ovr=%b expected 0 0", rx_error, rx_overrun);
    end
    tests++; if (baud_en !== 1'b0 || baud_en_16x !== 1'b0) begin
      fails++; $display("FAIL reset_baud: got %b %b expected 0 0", baud_en, baud_en_16x);
    end
    rst_n = 1'b0;
  endtask

  task automatic test_baud_ticks;
    int n16 = 0, n1 = 0, first16 = -1, last16 = -1, last1 = -1, gap1 = 0, badgap = 0, nocoinc = 0;
    for (int c = 0; c < 600; c++) begin
      if (baud_en_16x === 1'b1) begin
        if (last16 >= 0 && c - last16 != 16) badgap++;
        if (first16 < 0) first16 = c;
        last16 = c;
        n16++;
      end
      if (baud_en === 1'b1) begin
        if (baud_en_16x !== 1'b1) nocoinc++;
        if (last1 >= 0) gap1 = c - last1;
        last1 = c;
        n1++;
      end
      @(negedge clk);
    end
    tests++; if (first16 != 15) begin fails++; $display("FAIL baud16_first: got %0d expected 15", first16); end
    tests++; if (n16 != 37)     begin fails++; $display("FAIL baud16_count: got %0d expected 37", n16); end
    tests++; if (badgap != 0)   begin fails++; $display("FAIL baud16_gap: got %0d bad gaps expected 0", badgap); end
    tests++; if (n1 != 2)       begin fails++; $display("FAIL baud1_count: got %0d expected 2", n1); end
    tests++; if (last1 != 511 || gap1 != 256) begin
      fails++; $display("FAIL baud1_period: got last=%0d gap=%0d expected 511 256", last1, gap1);
    end
    tests++; if (nocoinc != 0)  begin fails++; $display("FAIL baud1_coincide: got %0d expected 0", nocoinc); end
  endtask

  task automatic test_single_byte;
    int e0;
    e0 = err_cnt;
    repeat (20) @(negedge clk);
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    tests++; if (empty !== 1'b0)     begin fails++; $display("FAIL single_empty: got %b expected 0", empty); end
    tests++; if (dout !== 8'hA5)     begin fails++; $display("FAIL single_dout: got %h expected a5", dout); end
    tests++; if (err_cnt != e0)      begin fails++; $display("FAIL single_err: got %0d errors expected 0", err_cnt - e0); end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    tests++; if (empty !== 1'b1)     begin fails++; $display("FAIL single_pop_empty: got %b expected 1", empty); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) send_frame(exp[i], even_par(exp[i]), 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL burst_busy: got %b expected 0", rx_busy); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (dout !== exp[i]) begin fails++; $display("FAIL burst_pop%0d: got %h expected %h", i, dout, exp[i]); end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL burst_empty: got %b expected 1", empty); end
  endtask

  task automatic test_errors;
    int e0, bc;
    bc = int'(divisor) * 16;
    e0 = err_cnt;
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL parity_err: got %0d pulses expected 1", err_cnt - e0); end
    tests++; if (empty !== 1'b1)    begin fails++; $display("FAIL parity_empty: got %b expected 1", empty); end

    // stop bit held low for 3/4 bit so the return to idle is not mistaken for a new start
    e0 = err_cnt;
    send_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) send_bit(i[0] == 1'b0, bc);
    send_bit(1'b0, bc);
    send_bit(1'b0, bc * 3 / 4);
    send_bit(1'b1, bc * 2);
    tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL frame_err: got %0d pulses expected 1", err_cnt - e0); end
    tests++; if (empty !== 1'b1)    begin fails++; $display("FAIL frame_empty: got %b expected 1", empty); end
    tests++; if (rx_busy !== 1'b0)  begin fails++; $display("FAIL frame_busy: got %b expected 0", rx_busy); end

    e0 = err_cnt;
    send_bit(1'b0, 10);
    tests++; if (rx_busy !== 1'b1)  begin fails++; $display("FAIL glitch_detect: got %b expected 1", rx_busy); end
    send_bit(1'b0, 54);
    send_bit(1'b1, bc);
    tests++; if (rx_busy !== 1'b0)  begin fails++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
    tests++; if (err_cnt != e0)     begin fails++; $display("FAIL glitch_err: got %0d pulses expected 0", err_cnt - e0); end
    tests++; if (empty !== 1'b1)    begin fails++; $display("FAIL glitch_empty: got %b expected 1", empty); end
  endtask

  task automatic test_full_overrun;
    int o0, bad;
    logic [7:0] d;
    divisor = 32'd4;
    repeat (32) @(negedge clk);
    o0 = ovr_cnt;
    for (int i = 0; i < 16; i++) begin
      d = 8'(i);
      send_frame(d, even_par(d), 1'b1);
    end
    repeat (4) @(negedge clk);
    tests++; if (full !== 1'b1)     begin fails++; $display("FAIL full_flag: got %b expected 1", full); end
    tests++; if (ovr_cnt != o0)     begin fails++; $display("FAIL early_overrun: got %0d expected 0", ovr_cnt - o0); end
`ifdef UART_RX_LEVEL_EN
    tests++; if (level !== 5'd16)   begin fails++; $display("FAIL level_full: got %0d expected 16", level); end
`endif
    send_frame(8'h10, even_par(8'h10), 1'b1);
    repeat (4) @(negedge clk);
    tests++; if (ovr_cnt - o0 != 1) begin fails++; $display("FAIL overrun: got %0d pulses expected 1", ovr_cnt - o0); end
    tests++; if (full !== 1'b1)     begin fails++; $display("FAIL overrun_full: got %b expected 1", full); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tests++; if (dout !== 8'(i)) begin fails++; $display("FAIL full_pop%0d: got %h expected %h", i, dout, 8'(i)); end
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    tests++; if (empty !== 1'b1 || full !== 1'b0) begin
      fails++; $display("FAIL drained: got empty=%b full=%b expected 1 0", empty, full);
    end
    divisor = 32'd16;
    repeat (32) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    int e0, bc;
    logic [7:0] d;
    bc = int'(divisor) * 16;
    d = 8'h3C;
    send_frame(8'h77, even_par(8'h77), 1'b1);
    repeat (4) @(negedge clk);
    tests++; if (empty !== 1'b0)   begin fails++; $display("FAIL pre_reset_fill: got %b expected 0", empty); end
    send_bit(1'b0, bc);
    for (int i = 0; i < 3; i++) send_bit(d[i], bc);
    tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL midframe_busy: got %b expected 1", rx_busy); end
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", rx_busy); end
    tests++; if (empty !== 1'b1)   begin fails++; $display("FAIL rst_empty: got %b expected 1", empty); end
    repeat (bc) @(negedge clk);
    e0 = err_cnt;
    send_frame(d, even_par(d), 1'b1);
    repeat (4) @(negedge clk);
    tests++; if (dout !== 8'h3C || empty !== 1'b0) begin
      fails++; $display("FAIL post_reset_rx: got %h empty=%b expected 3c empty=0", dout, empty);
    end
    tests++; if (err_cnt != e0)    begin fails++; $display("FAIL post_reset_err: got %0d expected 0", err_cnt - e0); end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    tests++; if (empty !== 1'b1)   begin fails++; $display("FAIL post_reset_pop: got %b expected 1", empty); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_baud_ticks;
    test_single_byte;
    test_back_to_back;
    test_errors;
    test_full_overrun;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_path.md
Name: uart_rx_path

Overview:
UART receive path: programmable baud tick generator, 16x-oversampling serial deserializer with optional parity check, and a first-word-fall-through (FWFT) receive FIFO. It sits between the serial `rx` pin and the bus-side reader. The 1x baud tick is also exported so a companion transmitter can share the generator.

Parameters:
- DATA_WIDTH, 8, data bits per frame and FIFO word width.
- ADDR_WIDTH, 4, FIFO address width; depth = 2^ADDR_WIDTH (16).
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_TYPE, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous reset, active-HIGH despite the name; clears all state when 1.
- divisor  in  32  clk cycles per 16x oversample tick.
- rx  in  1  serial input; idles high.
- rd_en  in  1  FIFO pop request.
- dout  out  DATA_WIDTH  FIFO head word (FWFT).
- full  out  1  FIFO holds 2^ADDR_WIDTH words.
- empty  out  1  FIFO holds 0 words.
- rx_busy  out  1  a frame is in progress.
- rx_error  out  1  one-cycle pulse on a parity or framing error.
- rx_overrun  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- baud_en  out  1  1x baud tick.
- baud_en_16x  out  1  16x baud tick.

Behaviour:
- Reset values: all outputs 0 except `empty`=1; `dout`=0; FSM in IDLE; all counters 0; synchronizer flops hold 1.
- Baud generator, 16x tick:
  - 32-bit counter counts 0..divisor-1; `baud_en_16x` pulses for one clk when the count equals divisor-1, then the counter wraps to 0.
  - divisor 0 or 1 → tick every cycle.
  - If divisor is changed mid-count so that count ≥ divisor-1, the generator ticks and wraps on the next cycle.
- Baud generator, 1x tick: a 4-bit counter advances on each 16x tick; `baud_en` pulses in the same cycle as every 16th 16x tick (counter = 15).
- rx input conditioning: `rx` passes through a 2-flop synchronizer. All sampling below uses the synchronized value.
- RX FSM (all timing in 16x ticks):
  - IDLE: a low on `rx` → START, tick counter cleared. `rx_busy`=1 in every state except IDLE.
  - START: after 8 ticks (mid-bit), sample. Low → DATA. High → false start, back to IDLE with no error.
  - DATA: every 16 ticks sample one bit, shifted in LSB first. After DATA_WIDTH bits → PARITY if PARITY_EN, else STOP.
  - PARITY: sample after 16 ticks. Check XOR(data, parity bit) = PARITY_TYPE.
  - STOP: sample after 16 ticks. Stop bit must be 1, otherwise framing error. Return to IDLE in the same cycle, i.e. mid-stop-bit.
- Frame completion (evaluated on the stop-bit sample cycle):
  - No error: one-cycle internal write of the byte into the FIFO.
  - Any error: `rx_error` pulses and the byte is discarded.
  - Good byte while FIFO full: `rx_overrun` pulses and the byte is dropped.
- FIFO:
  - Circular buffer with a (ADDR_WIDTH+1)-bit occupancy count.
  - `dout` = mem[rd_ptr] combinationally whenever not empty.
  - `rd_en` while empty is ignored.
  - Write while full is ignored.
  - Simultaneous write and read when full: both are performed and the count is unchanged.
  - Simultaneous write and read when empty: only the write is performed.
  - Pointers wrap modulo depth.
  - Write latency: a written byte is visible on `dout` and `empty` falls in the cycle after the internal write.
- Reset asserted mid-frame: the frame is abandoned, FSM goes to IDLE, FIFO contents are discarded.

Optional Feature:
- Macro UART_RX_LEVEL_EN.
- When defined: adds output `level` [ADDR_WIDTH:0] = current FIFO occupancy count, 0..2^ADDR_WIDTH.
- When undefined: the port is absent; all other behaviour is identical.

Test Plan:
- Baud ticks: divisor=16, release reset → `baud_en_16x` every 16 clks; `baud_en` every 256 clks, coincident with every 16th 16x tick.
- Single byte: divisor=16, send 0xA5 on `rx` with parity 0 and stop 1, 256 clks per bit → `empty` falls, `dout`=0xA5, no `rx_error`; one `rd_en` pulse → `empty`=1.
- Burst: frames 0x11, 0x22, 0x33 back to back → after all three frames, three pops return 0x11, 0x22, 0x33 in order; `rx_busy` low after the last stop bit.
- Errors: 0x01 with parity bit 0 → `rx_error` pulse, FIFO stays empty. 0x55 with stop bit 0 → `rx_error` pulse, nothing written. 4-tick low glitch on `rx` → returns to IDLE, no error.
- Full/overrun: 17 good frames (0x00..0x10) with no reads → `full`=1 after the 16th; the 17th raises `rx_overrun`; pops return 0x00..0x0F, then `empty`=1.
- Reset mid-frame: assert `rst_n` during DATA of a 0x3C frame → `rx_busy`=0, `empty`=1; the next full frame 0x3C is received correctly.
